branch_commit_queue: RTL and testbench
======================================

Name: branch_commit_queue

Overview:
In-order queue of predicted branches. It sits between the fetcher (writer) and the branch predictor table's update port (reader side).
- Fetcher pushes {table tag, predicted direction} when it consults the predictor.
- ROB commit pops the oldest entry with the resolved direction.
- The block issues the predictor update and flags mispredictions for pipeline flush.

Parameters:
- TAG_W, 8, predictor table index width (table holds 2^TAG_W counters).
- DEPTH, 16, queue entries; power of two.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rdy  in  1  global enable; low = hold all state.
- in_fetcher_br_ce  in  1  push a predicted branch.
- in_fetcher_tag  in  TAG_W  predictor index used for the prediction.
- in_fetcher_pred_jump  in  1  predicted taken.
- out_fetcher_full  out  1  queue full; fetcher must stall branch fetch.
- in_rob_br_ce  in  1  oldest branch commits this cycle.
- in_rob_jump_ce  in  1  resolved direction (1 = taken).
- in_rob_flush  in  1  external pipeline clear.
- out_bp_ce  out  1  predictor update strobe.
- out_bp_tag  out  TAG_W  index to update.
- out_bp_jump_ce  out  1  direction to train toward.
- out_rob_mispredict  out  1  one-cycle pulse: committed direction differed from prediction.
- out_count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - head, tail and count cleared to 0.
  - out_bp_ce=0, out_bp_tag=0, out_bp_jump_ce=0, out_rob_mispredict=0, out_fetcher_full=0.
  - Entry storage is not reset.
  - Reset mid-operation discards all entries immediately.
- rdy=0: no pointer/count/storage change. out_bp_ce and out_rob_mispredict are driven 0 that cycle; other outputs hold.
- Storage: circular buffer of DEPTH x {tag, pred}. head/tail are PTR_W bits and wrap modulo DEPTH naturally. count is PTR_W+1 bits.
- out_fetcher_full is combinational: count==DEPTH.
- Push (in_fetcher_br_ce=1 and not full):
  - Write entry at tail; tail+1, count+1.
  - A push while full is dropped, even if a commit occurs the same cycle.
- Commit (in_rob_br_ce=1 and count>0):
  - Read entry at head; head+1, count-1.
  - Next cycle: out_bp_ce=1, out_bp_tag=entry.tag, out_bp_jump_ce=in_rob_jump_ce.
  - Next cycle: out_rob_mispredict=(entry.pred != in_rob_jump_ce).
  - Latency is exactly 1 cycle; outputs are registered.
  - Commit while empty is a protocol violation: ignored, no update, no mispredict.
- Push and commit in the same cycle, count>0 and not full: both proceed; count unchanged.
- Mispredict clear:
  - A mispredicting commit clears the queue at that same clock edge: head=tail=0, count=0.
  - A same-cycle push is discarded (wrong-path).
  - The update and mispredict pulse are still emitted next cycle.
- in_rob_flush=1:
  - Same clearing as above.
  - A same-cycle commit is still processed for its update/mispredict outputs before clearing.
  - A same-cycle push is discarded.
- Update strobe is a pulse: out_bp_ce=0 in any cycle not following a valid commit.

Optional Feature:
- Macro BCQ_STATS_EN.
- Defined:
  - Adds outputs out_stat_commits[31:0] and out_stat_mispredicts[31:0].
  - Each counter increments on a valid commit / a mispredicting commit respectively.
  - Counters wrap at 2^32, reset to 0 on rst, are not cleared by flush, and hold when rdy=0.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared constants include file: TRUE/FALSE, BP_TAG_WIDTH (= TAG_W), BP_TABLE_SIZE, BCQ_DEPTH, BCQ_PTR_WIDTH.
- One natural sub-module: bcq_fifo_mem. It is the DEPTH x (TAG_W+1) register array with one write port and one combinational read port. Pointers, control and output registers stay in the top module.

Test Plan:
- Reset, then push tag 8'h12 pred=1; commit jump=1 -> next cycle out_bp_ce=1, tag=8'h12, jump=1, mispredict=0, count=0.
- Push tags 0x01,0x02,0x03 (pred 0,0,0); commit jump=0,1 -> second commit: mispredict=1 with tag 0x02 update; next cycle count=0, third entry discarded.
- Push 16 entries -> out_fetcher_full=1, count=16; 17th push dropped; 16 commits return tags in push order; pointers wrap cleanly on a further 4 push/commit pairs.
- Commit with count=0 -> out_bp_ce=0, mispredict=0, count stays 0.
- rdy=0 for 3 cycles with push and commit asserted -> count and outputs unchanged, out_bp_ce=0; rdy=1 resumes normally.
- Assert rst asynchronously between clock edges with count=5 -> count=0 and all outputs 0 before the next edge; with BCQ_STATS_EN, counters read 0.

Source files
------------

// File: rtl/branch_commit_queue_pkg.sv
// Shared constants and entry type for the branch commit queue.
package branch_commit_queue_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned TAG_W = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam int unsigned BP_TAG_WIDTH  = TAG_W;
    localparam int unsigned BP_TABLE_SIZE = 2 ** TAG_W;
    localparam int unsigned BCQ_DEPTH     = DEPTH;
    localparam int unsigned BCQ_PTR_WIDTH = PTR_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             pred;
    } bcq_entry_t;

endpackage

// File: rtl/branch_commit_queue_if.sv
// Fetcher / ROB / predictor-update signal bundle. BCQ_STATS_EN adds the statistics outputs.
interface branch_commit_queue_if;
    import branch_commit_queue_pkg::*;

    logic             in_fetcher_br_ce;
    logic [TAG_W-1:0] in_fetcher_tag;
    logic             in_fetcher_pred_jump;
    logic             out_fetcher_full;
    logic             in_rob_br_ce;
    logic             in_rob_jump_ce;
    logic             in_rob_flush;
    logic             out_bp_ce;
    logic [TAG_W-1:0] out_bp_tag;
    logic             out_bp_jump_ce;
    logic             out_rob_mispredict;
    logic [CNT_W-1:0] out_count;
`ifdef BCQ_STATS_EN
    logic [31:0]      out_stat_commits;
    logic [31:0]      out_stat_mispredicts;
`endif

    modport master (
        output in_fetcher_br_ce, in_fetcher_tag, in_fetcher_pred_jump,
        output in_rob_br_ce, in_rob_jump_ce, in_rob_flush,
        input  out_fetcher_full, out_bp_ce, out_bp_tag, out_bp_jump_ce,
        input  out_rob_mispredict, out_count
`ifdef BCQ_STATS_EN
        , input out_stat_commits, out_stat_mispredicts
`endif
    );

    modport slave (
        input  in_fetcher_br_ce, in_fetcher_tag, in_fetcher_pred_jump,
        input  in_rob_br_ce, in_rob_jump_ce, in_rob_flush,
        output out_fetcher_full, out_bp_ce, out_bp_tag, out_bp_jump_ce,
        output out_rob_mispredict, out_count
`ifdef BCQ_STATS_EN
        , output out_stat_commits, out_stat_mispredicts
`endif
    );

endinterface

// File: rtl/branch_commit_queue_fifo_mem.sv
// Entry storage: DEPTH x {tag, pred}, one write port, combinational read port, not reset.
module bcq_fifo_mem
    import branch_commit_queue_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  bcq_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output bcq_entry_t       rdata
);

    bcq_entry_t mem_q [DEPTH];
    bcq_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_commit_queue.sv
// In-order queue of predicted branches feeding predictor updates and mispredict flushes.
// Optional statistics counters under BCQ_STATS_EN.
module branch_commit_queue
    import branch_commit_queue_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    branch_commit_queue_if.slave bus
);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bp_ce_q, bp_ce_d;
    logic [TAG_W-1:0] bp_tag_q, bp_tag_d;
    logic             bp_jump_q, bp_jump_d;
    logic             mispredict_q, mispredict_d;

    logic       full_c, push_ok, commit_ok, mispred, clear, wr_en;
    bcq_entry_t wr_entry, rd_entry;

    assign wr_entry = '{tag: bus.in_fetcher_tag, pred: bus.in_fetcher_pred_jump};

    bcq_fifo_mem u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    // A mispredicting commit or a flush empties the queue and drops any same-cycle push.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        bp_ce_d      = FALSE;
        bp_tag_d     = bp_tag_q;
        bp_jump_d    = bp_jump_q;
        mispredict_d = FALSE;
        wr_en        = FALSE;

        full_c    = (count_q == CNT_W'(DEPTH));
        push_ok   = bus.in_fetcher_br_ce && !full_c;
        commit_ok = bus.in_rob_br_ce && (count_q != '0);
        mispred   = commit_ok && (rd_entry.pred != bus.in_rob_jump_ce);
        clear     = mispred || bus.in_rob_flush;

        if (rdy) begin
            if (commit_ok) begin
                bp_ce_d      = TRUE;
                bp_tag_d     = rd_entry.tag;
                bp_jump_d    = bus.in_rob_jump_ce;
                mispredict_d = mispred;
            end
            if (clear) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push_ok) begin
                    wr_en  = TRUE;
                    tail_d = tail_q + PTR_W'(1);
                end
                if (commit_ok) head_d = head_q + PTR_W'(1);
                count_d = count_q + CNT_W'(push_ok) - CNT_W'(commit_ok);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            bp_ce_q      <= FALSE;
            bp_tag_q     <= '0;
            bp_jump_q    <= FALSE;
            mispredict_q <= FALSE;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            bp_ce_q      <= bp_ce_d;
            bp_tag_q     <= bp_tag_d;
            bp_jump_q    <= bp_jump_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign bus.out_fetcher_full   = full_c;
    assign bus.out_bp_ce          = bp_ce_q;
    assign bus.out_bp_tag         = bp_tag_q;
    assign bus.out_bp_jump_ce     = bp_jump_q;
    assign bus.out_rob_mispredict = mispredict_q;
    assign bus.out_count          = count_q;

`ifdef BCQ_STATS_EN
    logic [31:0] stat_commits_q, stat_commits_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Counters survive flushes; only rst clears them.
    always_comb begin
        stat_commits_d     = stat_commits_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (rdy) begin
            stat_commits_d     = stat_commits_q + 32'(commit_ok);
            stat_mispredicts_d = stat_mispredicts_q + 32'(mispred);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_commits_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_commits_q     <= stat_commits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign bus.out_stat_commits     = stat_commits_q;
    assign bus.out_stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_commit_queue.sv
// Randomized and directed checks of branch_commit_queue against a queue-based reference model.
module tb_branch_commit_queue;
    import branch_commit_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    branch_commit_queue_if bus ();

    branch_commit_queue dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of {tag, pred} plus expected registered outputs.
    logic [8:0] mq [$];
    logic       exp_bp_ce, exp_jump, exp_mis;
    logic [7:0] exp_tag;
    int unsigned exp_commits, exp_mis_cnt;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ":count"}, 32'(bus.out_count), 32'(mq.size()));
        check_eq({ph, ":full"}, 32'(bus.out_fetcher_full), 32'(mq.size() == DEPTH));
        check_eq({ph, ":bp_ce"}, 32'(bus.out_bp_ce), 32'(exp_bp_ce));
        check_eq({ph, ":bp_tag"}, 32'(bus.out_bp_tag), 32'(exp_tag));
        check_eq({ph, ":bp_jump"}, 32'(bus.out_bp_jump_ce), 32'(exp_jump));
        check_eq({ph, ":mispredict"}, 32'(bus.out_rob_mispredict), 32'(exp_mis));
`ifdef BCQ_STATS_EN
        check_eq({ph, ":stat_commits"}, bus.out_stat_commits, exp_commits);
        check_eq({ph, ":stat_mispredicts"}, bus.out_stat_mispredicts, exp_mis_cnt);
`endif
    endtask

    task automatic step(input logic r, input logic p, input logic [7:0] t, input logic pr,
                        input logic c, input logic j, input logic f, input string ph);
        logic       full, pok, cok, mis;
        logic [8:0] e;
        @(negedge clk);
        rdy                      = r;
        bus.in_fetcher_br_ce     = p;
        bus.in_fetcher_tag       = t;
        bus.in_fetcher_pred_jump = pr;
        bus.in_rob_br_ce         = c;
        bus.in_rob_jump_ce       = j;
        bus.in_rob_flush         = f;
        exp_bp_ce = 1'b0;
        exp_mis   = 1'b0;
        if (r) begin
            full = (mq.size() == DEPTH);
            pok  = p && !full;
            cok  = c && (mq.size() > 0);
            mis  = 1'b0;
            if (cok) begin
                e         = mq.pop_front();
                exp_bp_ce = 1'b1;
                exp_tag   = e[8:1];
                exp_jump  = j;
                mis       = (e[0] != j);
                exp_mis   = mis;
                exp_commits++;
                if (mis) exp_mis_cnt++;
            end
            if (mis || f) mq.delete();
            else if (pok) mq.push_back({t, pr});
        end
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_bp_ce   = 1'b0;
        exp_tag     = '0;
        exp_jump    = 1'b0;
        exp_mis     = 1'b0;
        exp_commits = 0;
        exp_mis_cnt = 0;
    endtask

    initial begin
        logic [7:0] t;
        logic       p, c, j, f, r, pr;
        bit         push_heavy;

        rst = 1'b1;
        rdy = 1'b0;
        bus.in_fetcher_br_ce     = 1'b0;
        bus.in_fetcher_tag       = '0;
        bus.in_fetcher_pred_jump = 1'b0;
        bus.in_rob_br_ce         = 1'b0;
        bus.in_rob_jump_ce       = 1'b0;
        bus.in_rob_flush         = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single push/commit, correct prediction
        step(1, 1, 8'h12, 1, 0, 0, 0, "tp1_push");
        step(1, 0, 8'h00, 0, 1, 1, 0, "tp1_commit");
        check_eq("tp1_tag_const", 32'(bus.out_bp_tag), 32'h12);
        check_eq("tp1_mis_const", 32'(bus.out_rob_mispredict), 32'h0);

        // Mispredict on second commit discards the third entry
        step(1, 1, 8'h01, 0, 0, 0, 0, "tp2_push1");
        step(1, 1, 8'h02, 0, 0, 0, 0, "tp2_push2");
        step(1, 1, 8'h03, 0, 0, 0, 0, "tp2_push3");
        step(1, 0, 8'h00, 0, 1, 0, 0, "tp2_commit1");
        step(1, 0, 8'h00, 0, 1, 1, 0, "tp2_commit2");
        check_eq("tp2_mis_const", 32'(bus.out_rob_mispredict), 32'h1);
        check_eq("tp2_tag_const", 32'(bus.out_bp_tag), 32'h02);
        check_eq("tp2_count_const", 32'(bus.out_count), 32'h0);
        step(1, 0, 8'h00, 0, 0, 0, 0, "tp2_idle");

        // Fill to full, drop 17th push, drain in order, then wrap
        for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h40 + i), i[0], 0, 0, 0, "tp3_fill");
        check_eq("tp3_full_const", 32'(bus.out_fetcher_full), 32'h1);
        step(1, 1, 8'hEE, 0, 1, 0, 0, "tp3_push_full_commit");
        step(1, 1, 8'hEF, 0, 0, 0, 0, "tp3_refill");
        for (int i = 0; i < 16; i++) step(1, 0, 8'h00, 0, 1, mq[0][0], 0, "tp3_drain");
        check_eq("tp3_empty_const", 32'(bus.out_count), 32'h0);
        step(1, 1, 8'h90, 1, 0, 0, 0, "tp3_wrap_push");
        for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h91 + i), 1, 1, 1, 0, "tp3_wrap_pair");
        step(1, 0, 8'h00, 0, 1, 1, 0, "tp3_wrap_last");

        // Commit while empty is ignored
        step(1, 0, 8'h00, 0, 1, 0, 0, "tp4_empty_commit");
        check_eq("tp4_bp_ce_const", 32'(bus.out_bp_ce), 32'h0);

        // rdy low holds everything
        step(1, 1, 8'hA1, 0, 0, 0, 0, "tp5_push1");
        step(1, 1, 8'hA2, 1, 0, 0, 0, "tp5_push2");
        for (int i = 0; i < 3; i++) step(0, 1, 8'hA3, 1, 1, 1, 0, "tp5_stall");
        check_eq("tp5_count_const", 32'(bus.out_count), 32'h2);
        step(1, 0, 8'h00, 0, 1, 0, 0, "tp5_resume");

        // Flush with same-cycle commit and push
        step(1, 1, 8'hB1, 1, 0, 0, 0, "flush_push");
        step(1, 1, 8'hB2, 0, 1, 1, 1, "flush_commit");

        // Randomized traffic
        push_heavy = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) push_heavy = ~push_heavy;
            r  = ($urandom % 10) != 0;
            p  = push_heavy ? (($urandom % 10) < 8) : (($urandom % 10) < 3);
            c  = push_heavy ? (($urandom % 10) < 3) : (($urandom % 10) < 8);
            t  = 8'($urandom);
            pr = 1'($urandom);
            if (mq.size() > 0 && ($urandom % 25) != 0) j = mq[0][0];
            else j = 1'($urandom);
            f  = ($urandom % 80) == 0;
            step(r, p, t, pr, c, j, f, "rand");
        end

        // Async reset between edges with entries queued
        for (int i = 0; i < 5; i++) step(1, 1, 8'(8'hC0 + i), 0, 0, 0, 0, "rst_fill");
        step(1, 0, 8'h00, 0, 1, 0, 0, "rst_commit");
        step(1, 1, 8'hC7, 0, 0, 0, 0, "rst_fill6");
        @(negedge clk);
        bus.in_fetcher_br_ce = 1'b0;
        bus.in_rob_br_ce     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 8'h5A, 1, 0, 0, 0, "post_rst_push");
        step(1, 0, 8'h00, 0, 1, 1, 0, "post_rst_commit");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
